uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clock cycles per serial bit (100 MHz / 115200 baud).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, number of buffered bytes; power of two, at least 2.
REQ-003 Clocking SHALL be one clock, reset synchronous and active-high.
REQ-004 Port clk  input  1  system clock; all state changes on rising edge.
REQ-005 Port rst  input  1  synchronous active-high reset.
REQ-006 Port tx_go  input  1  push request; one byte accepted per cycle while tx_full=0.
REQ-007 Port txdata  input  8  byte to transmit; sampled when tx_go=1 and tx_full=0.
REQ-008 Port tx_full  output  1  FIFO holds FIFO_DEPTH bytes.
REQ-009 Port tx_busy  output  1  FIFO non-empty or frame in progress.
REQ-010 Port tx_done  output  1  one-cycle pulse in the cycle after a stop bit completes.
REQ-011 Port txd  output  1  serial line, idle high.

Function
REQ-012 Frame SHALL be 8N1: start bit 0, data bits LSB first, one stop bit 1; each bit lasts exactly CLKS_PER_BIT cycles.
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP.
- IDLE -> START when the FIFO is non-empty; pop the head into the shift register in the same cycle.
- START -> DATA after CLKS_PER_BIT cycles.
- DATA -> STOP after 8 bit periods.
- STOP -> IDLE after CLKS_PER_BIT cycles, with tx_done=1 in the following cycle.
REQ-014 txd SHALL be registered; it changes only at bit boundaries and is 1 in IDLE and STOP.
REQ-015 Latency SHALL be fixed: from tx_go accepted in cycle N into an empty, idle block, txd falls in cycle N+2.
REQ-016 Back-to-back transmission: if the FIFO is non-empty at STOP end, the next START SHALL follow after exactly one IDLE cycle, with no extra stop time.
REQ-017 A push while tx_full=1 SHALL be ignored: data is dropped, no state change, no error flag.
REQ-018 Push and pop in the same cycle SHALL both take effect, leaving the count unchanged; this is legal when full.
REQ-019 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH.
- full = index bits equal and MSBs differ.
- empty = pointers equal.
REQ-020 Baud counter SHALL be $clog2(CLKS_PER_BIT) bits wide and count 0..CLKS_PER_BIT-1; a bit ends when count = CLKS_PER_BIT-1.
REQ-021 The bit index SHALL be 3 bits; DATA exits when index=7 and the bit ends.
REQ-022 tx_busy SHALL equal (state != IDLE) OR (FIFO non-empty), registered-equivalent with no combinational path from tx_go.

Reset
REQ-023 While rst=1 the block SHALL hold: state IDLE, txd=1, tx_done=0, tx_full=0, tx_busy=0, pointers=0, counters=0.
REQ-024 Reset mid-frame SHALL abort the frame, discard FIFO contents, and return txd to 1 in the next cycle; no tx_done is produced.
REQ-025 FIFO storage SHALL not need reset; only pointers are reset.

Structure
REQ-026 A shared package uart_pkg SHALL hold the tx_state_t enum (IDLE, START, DATA, STOP) and localparam defaults for CLKS_PER_BIT and FIFO_DEPTH.
REQ-027 The FIFO SHALL be a separate sub-module tx_fifo (parameter DEPTH) with push, pop, din, dout, full, empty; dout is valid combinationally from the head.
REQ-028 The block SHALL be plugged into uart_unit as the transmit half, driving uart_done from tx_done in send mode.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-029 Single byte: push 0xA5 at cycle 0 -> txd falls at cycle 2, samples 0,1,0,1,0,0,1,0,1 every 4 cycles, tx_done pulse at cycle 42, tx_busy=0 afterwards.
REQ-030 Burst: push 0x00,0xFF,0x55,0x3C on consecutive cycles -> tx_full=1 after the 4th push minus one pop (check exact count), four frames separated by exactly 1 idle cycle, four tx_done pulses.
REQ-031 Overflow: 6 pushes 0x01..0x06 while the first frame is in progress -> 0x06 (and 0x05 if full) dropped, the line carries only the accepted bytes in order.
REQ-032 Simultaneous push/pop when full -> count stays 4, no data lost or duplicated, pointer wrap exercised by 10+ bytes in total.
REQ-033 Reset at bit 3 of byte 0x81 with 2 bytes queued -> txd=1 next cycle, tx_busy=0, no tx_done, the following push of 0x42 transmits correctly.
REQ-034 A scoreboard SHALL decode txd at mid-bit for every test and compare against pushed bytes.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared transmit FSM state type and default UART parameters.
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  localparam int CLKS_PER_BIT_DEF = 868;
  localparam int FIFO_DEPTH_DEF = 4;
endpackage

// File: rtl/tx_fifo.sv
// tx_fifo: byte FIFO with wrap-bit pointers and a combinational head output.
module tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wp, rp;
  logic [7:0] mem [DEPTH];
  logic rd, wr;
  assign full = (wp[AW-1:0] == rp[AW-1:0]) && (wp[AW] != rp[AW]);
  assign empty = wp == rp;
  assign dout = mem[rp[AW-1:0]];
  assign rd = pop && !empty;
  // a simultaneous pop frees the head slot, so a push into a full FIFO is taken then
  assign wr = push && (!full || rd);
  always_ff @(posedge clk)
    if (wr) mem[wp[AW-1:0]] <= din;
  always_ff @(posedge clk)
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
    end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: buffered 8N1 serial transmitter with a registered line output.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_go,
  input  logic [7:0] txdata,
  output logic       tx_full,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       txd
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  tx_state_t state;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [7:0] sh, head;
  logic empty, pop, bit_end;
  assign bit_end = cnt == LAST;
  assign pop = (state == IDLE) && !empty;
  assign tx_busy = (state != IDLE) || !empty;
  tx_fifo #(.DEPTH(FIFO_DEPTH)) fifo (
    .clk(clk),
    .rst(rst),
    .push(tx_go),
    .pop(pop),
    .din(txdata),
    .dout(head),
    .full(tx_full),
    .empty(empty)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      txd <= 1'b1;
      tx_done <= 1'b0;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
    end else begin
      tx_done <= 1'b0;
      cnt <= (state == IDLE || bit_end) ? '0 : cnt + 1'b1;
      case (state)
        IDLE: if (!empty) begin
          state <= START;
          txd <= 1'b0;
          sh <= head;
          idx <= '0;
        end
        START: if (bit_end) begin
          state <= DATA;
          txd <= sh[0];
          sh <= sh >> 1;
        end
        DATA: if (bit_end) begin
          if (idx == 3'd7) begin
            state <= STOP;
            txd <= 1'b1;
          end else begin
            txd <= sh[0];
            sh <= sh >> 1;
            idx <= idx + 3'd1;
          end
        end
        STOP: if (bit_end) begin
          state <= IDLE;
          tx_done <= 1'b1;
        end
      endcase
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed checks of uart_tx timing, FIFO limits and reset, with a mid-bit line decoder.
module tb_uart_tx;
  logic clk = 1'b0, rst = 1'b1, tx_go = 1'b0;
  logic [7:0] txdata = 8'h00;
  logic tx_full, tx_busy, tx_done, txd;
  int total = 0, bad = 0;
  int cyc = 0, done_cnt = 0, rx_cnt = 0;
  logic [7:0] exp_q[$];
  int starts[$];

  uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .tx_go(tx_go),
    .txdata(txdata),
    .tx_full(tx_full),
    .tx_busy(tx_busy),
    .tx_done(tx_done),
    .txd(txd)
  );

  always #5 clk = ~clk;

  task automatic chk(input logic [31:0] obs, input logic [31:0] want, input string tag);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic push(input logic [7:0] d, input bit acc);
    tx_go = 1'b1;
    txdata = d;
    if (acc) exp_q.push_back(d);
    @(negedge clk);
    tx_go = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!tx_busy) break;
    end
    chk(tx_busy, 0, "idle_timeout");
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200; i++) begin
      if (tx_done) break;
      @(negedge clk);
    end
    chk(tx_done, 1, "done_timeout");
  endtask

  // line decoder: t counts cycles from the first low start-bit cycle
  initial begin
    bit active = 0;
    int t = 0;
    logic [7:0] rx = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (tx_done) done_cnt++;
      if (rst) active = 0;
      else if (!active) begin
        if (txd === 1'b0) begin
          active = 1;
          t = 0;
          starts.push_back(cyc);
        end
      end else begin
        t++;
        if (t == 2) chk(txd, 0, "start_bit");
        else if (t >= 6 && t <= 34 && (t - 6) % 4 == 0) rx[(t - 6) / 4] = txd;
        else if (t == 38) begin
          chk(txd, 1, "stop_bit");
          chk(exp_q.size() > 0, 1, "frame_expected");
          if (exp_q.size() > 0) chk(rx, exp_q.pop_front(), "rx_byte");
          rx_cnt++;
          active = 0;
        end
      end
    end
  end

  initial begin
    logic [8:0] pat = 9'b101001010;
    int d0, r0;
    repeat (3) @(negedge clk);
    chk(txd, 1, "rst_txd");
    chk(tx_full, 0, "rst_full");
    chk(tx_busy, 0, "rst_busy");
    chk(tx_done, 0, "rst_done");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // single byte, exact cycle timing
    push(8'hA5, 1);
    chk(txd, 1, "lat_c1");
    chk(tx_busy, 1, "busy_c1");
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) repeat (4) @(negedge clk);
      chk(txd, pat[i], $sformatf("a5_bit%0d", i));
    end
    repeat (4) @(negedge clk);
    chk(txd, 1, "a5_stop_c38");
    repeat (3) @(negedge clk);
    chk(tx_done, 0, "a5_done_c41");
    @(negedge clk);
    chk(tx_done, 1, "a5_done_c42");
    @(negedge clk);
    chk(tx_done, 0, "a5_done_c43");
    chk(tx_busy, 0, "a5_busy_c43");
    wait_idle();
    chk(rx_cnt, 1, "a5_rx_cnt");

    // burst of four: one pop overlaps, so three remain queued
    starts.delete();
    d0 = done_cnt; r0 = rx_cnt;
    push(8'h00, 1); push(8'hFF, 1); push(8'h55, 1); push(8'h3C, 1);
    chk(tx_full, 0, "burst_full");
    chk(tx_busy, 1, "burst_busy");
    wait_idle();
    chk(done_cnt - d0, 4, "burst_done");
    chk(rx_cnt - r0, 4, "burst_rx");
    chk(starts.size(), 4, "burst_starts");
    for (int i = 1; i < 4 && i < starts.size(); i++)
      chk(starts[i] - starts[i-1], 41, $sformatf("burst_gap%0d", i));

    // overflow during a frame: 0x06 dropped
    d0 = done_cnt; r0 = rx_cnt;
    push(8'h01, 1);
    repeat (4) @(negedge clk);
    push(8'h02, 1); push(8'h03, 1); push(8'h04, 1);
    chk(tx_full, 0, "ovf_not_full");
    push(8'h05, 1);
    chk(tx_full, 1, "ovf_full");
    push(8'h06, 0);
    chk(tx_full, 1, "ovf_still_full");
    wait_idle();
    chk(rx_cnt - r0, 5, "ovf_rx");
    chk(done_cnt - d0, 5, "ovf_done");

    // push coinciding with pop while full keeps the count at four
    d0 = done_cnt; r0 = rx_cnt;
    push(8'h10, 1);
    repeat (4) @(negedge clk);
    push(8'h11, 1); push(8'h12, 1); push(8'h13, 1); push(8'h14, 1);
    chk(tx_full, 1, "pp_full");
    for (int k = 0; k < 6; k++) begin
      wait_done();
      chk(tx_full, 1, $sformatf("pp_pre%0d", k));
      push(8'h15 + 8'(k), 1);
      chk(tx_full, 1, $sformatf("pp_post%0d", k));
    end
    wait_idle();
    chk(rx_cnt - r0, 11, "pp_rx");
    chk(done_cnt - d0, 11, "pp_done");

    // reset during data bit 3 of 0x81 with two bytes queued
    push(8'h81, 1); push(8'h11, 1); push(8'h22, 1);
    repeat (16) @(negedge clk);
    chk(tx_busy, 1, "rst_mid_busy");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    chk(txd, 1, "rst_mid_txd");
    chk(tx_busy, 0, "rst_mid_busy0");
    chk(tx_full, 0, "rst_mid_full");
    d0 = done_cnt; r0 = rx_cnt;
    repeat (60) @(negedge clk);
    chk(done_cnt - d0, 0, "rst_no_done");
    chk(rx_cnt - r0, 0, "rst_no_frame");
    chk(tx_busy, 0, "rst_stays_idle");
    push(8'h42, 1);
    wait_idle();
    chk(rx_cnt - r0, 1, "post_rst_rx");
    chk(done_cnt - d0, 1, "post_rst_done");

    chk(exp_q.size(), 0, "exp_drained");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
